// File: rtl/mc_pkg.sv
// mc_pkg -- shared definitions for the multicycle controller.
//   * FSM state encoding (3-bit, exposed on the controller's state output)
//   * MIPS opcode constants decoded by the controller
//   * ALU operation select constants driven on aluop
//   * ctrl_t: one bundle holding every datapath strobe and select
package mc_pkg;

  localparam logic [2:0] ST_FETCH  = 3'd0;
  localparam logic [2:0] ST_DECODE = 3'd1;
  localparam logic [2:0] ST_EXEC   = 3'd2;
  localparam logic [2:0] ST_MEM    = 3'd3;
  localparam logic [2:0] ST_WB     = 3'd4;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  typedef struct packed {
    logic       pc_wr;
    logic       ir_wr;
    logic       reg_wr;
    logic       mem_read;
    logic       mem_write;
    logic       regdst;
    logic       alusrc;
    logic       memtoreg;
    logic       pcsrc;
    logic       jump;
    logic [1:0] aluop;
  } ctrl_t;

  // Opcodes that take the normal DECODE -> EXEC path.
  function automatic logic is_exec_op(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) || (op == OP_BEQ);
  endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// multicycle_ctrl_if -- controller <-> datapath signal bundle.
//   Datapath -> controller: opcode (latched instr[31:26]), zero (ALU flag),
//                           mem_ready (memory access complete)
//   Controller -> datapath: pc_wr, ir_wr, reg_wr, mem_read, mem_write,
//                           regdst, alusrc, memtoreg, pcsrc, jump, aluop[1:0]
//
// Memory handshake: mem_read / mem_write act as the request and stay high
// every cycle the controller waits in FETCH or MEM; the access completes on
// the first rising edge where the request is high and mem_ready is 1. The
// controller never raises mem_read and mem_write together, and it may drop
// the request without completion only on a wait timeout.
interface multicycle_ctrl_if;
  logic [5:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       pc_wr;
  logic       ir_wr;
  logic       reg_wr;
  logic       mem_read;
  logic       mem_write;
  logic       regdst;
  logic       alusrc;
  logic       memtoreg;
  logic       pcsrc;
  logic       jump;
  logic [1:0] aluop;

  modport master (
    input  opcode, zero, mem_ready,
    output pc_wr, ir_wr, reg_wr, mem_read, mem_write,
           regdst, alusrc, memtoreg, pcsrc, jump, aluop
  );

  modport slave (
    output opcode, zero, mem_ready,
    input  pc_wr, ir_wr, reg_wr, mem_read, mem_write,
           regdst, alusrc, memtoreg, pcsrc, jump, aluop
  );
endinterface

// File: rtl/mc_wait_cnt.sv
// mc_wait_cnt -- memory wait counter with timeout compare.
//   clk, rst   : clock, asynchronous active-low reset
//   wait_en    : controller is in a memory-wait state (FETCH or MEM)
//   mem_ready  : memory access complete
//   timeout    : this cycle is the MEM_WAIT_MAX-th consecutive cycle in the
//                wait state with mem_ready low
// The count is 0 on the first cycle of every wait state because it clears
// whenever the controller is not holding (outside a wait state, on a
// completed access, or on timeout).
module mc_wait_cnt #(
  parameter int MEM_WAIT_MAX = 15,
  parameter int CNT_W        = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic wait_en,
  input  logic mem_ready,
  output logic timeout
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // cnt_q counts the low cycles already spent, so the current cycle is the
  // MEM_WAIT_MAX-th one when cnt_q == MEM_WAIT_MAX-1. A ready on that same
  // cycle is a normal completion.
  assign timeout = wait_en && !mem_ready && (cnt_q == CNT_W'(MEM_WAIT_MAX - 1));

  always_comb begin
    cnt_d = '0;
    if (wait_en && !mem_ready && !timeout) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl -- five-state multicycle MIPS control FSM.
//   clk    : clock, rising edge
//   rst    : asynchronous active-low reset
//   bus    : multicycle_ctrl_if.master (opcode/zero/mem_ready in,
//            datapath strobes and selects out)
//   state  : current FSM state (FETCH=0 DECODE=1 EXEC=2 MEM=3 WB=4)
//   err    : one-cycle pulse, high in the first cycle after an illegal
//            opcode in DECODE or a memory-wait timeout
// Optional feature: define MULTICYCLE_JUMP_EN to execute j in DECODE
// (jump=1, pc_wr=1, back to FETCH); otherwise j is an illegal opcode.
//
// Strobes are decodes of the state register, qualified by the inputs the
// state is waiting on (mem_ready in FETCH/MEM, zero in EXEC of beq). All
// strobes are forced low while rst is asserted.
module multicycle_ctrl
  import mc_pkg::*;
#(
  parameter int MEM_WAIT_MAX = 15,
  parameter int CNT_W        = 4
) (
  input  logic                clk,
  input  logic                rst,
  multicycle_ctrl_if.master   bus,
  output logic [2:0]          state,
  output logic                err
);

`ifdef MULTICYCLE_JUMP_EN
  localparam logic JUMP_EN = 1'b1;
`else
  localparam logic JUMP_EN = 1'b0;
`endif

  logic [2:0] state_q, state_d;
  logic       err_q, err_d;
  logic       wait_en;
  logic       timeout;
  logic       is_r, is_lw, is_sw, is_beq, is_j;
  ctrl_t      ctrl;

  assign is_r   = (bus.opcode == OP_RTYPE);
  assign is_lw  = (bus.opcode == OP_LW);
  assign is_sw  = (bus.opcode == OP_SW);
  assign is_beq = (bus.opcode == OP_BEQ);
  assign is_j   = JUMP_EN && (bus.opcode == OP_J);

  assign wait_en = (state_q == ST_FETCH) || (state_q == ST_MEM);

  mc_wait_cnt #(
    .MEM_WAIT_MAX (MEM_WAIT_MAX),
    .CNT_W        (CNT_W)
  ) u_wait_cnt (
    .clk       (clk),
    .rst       (rst),
    .wait_en   (wait_en),
    .mem_ready (bus.mem_ready),
    .timeout   (timeout)
  );

  // Next state and error pulse.
  always_comb begin
    state_d = state_q;
    err_d   = 1'b0;
    case (state_q)
      ST_FETCH: begin
        if (timeout) begin
          state_d = ST_FETCH;   // re-enter FETCH; the counter restarts
          err_d   = 1'b1;
        end else if (bus.mem_ready) begin
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if (is_exec_op(bus.opcode)) begin
          state_d = ST_EXEC;
        end else if (is_j) begin
          state_d = ST_FETCH;
        end else begin
          state_d = ST_FETCH;
          err_d   = 1'b1;
        end
      end
      ST_EXEC: begin
        if (is_lw || is_sw) begin
          state_d = ST_MEM;
        end else if (is_r) begin
          state_d = ST_WB;
        end else begin
          state_d = ST_FETCH;   // beq completes here
        end
      end
      ST_MEM: begin
        if (timeout) begin
          state_d = ST_FETCH;
          err_d   = 1'b1;
        end else if (bus.mem_ready) begin
          state_d = is_lw ? ST_WB : ST_FETCH;
        end
      end
      ST_WB: begin
        state_d = ST_FETCH;
      end
      default: begin
        state_d = ST_FETCH;
      end
    endcase
  end

  // Output decode. The timeout cycle drops the pending memory request.
  always_comb begin
    ctrl = '0;
    if (rst) begin
      case (state_q)
        ST_FETCH: begin
          ctrl.mem_read = !timeout;
          ctrl.ir_wr    = bus.mem_ready;
          ctrl.pc_wr    = bus.mem_ready;
        end
        ST_DECODE: begin
          ctrl.jump  = is_j;
          ctrl.pc_wr = is_j;
        end
        ST_EXEC: begin
          if (is_r) begin
            ctrl.aluop = ALU_FUNCT;
          end else if (is_lw || is_sw) begin
            ctrl.aluop  = ALU_ADD;
            ctrl.alusrc = 1'b1;
          end else if (is_beq) begin
            ctrl.aluop = ALU_SUB;
            ctrl.pcsrc = bus.zero;
            ctrl.pc_wr = bus.zero;
          end
        end
        ST_MEM: begin
          ctrl.mem_read  = is_lw && !timeout;
          ctrl.mem_write = is_sw && !timeout;
        end
        ST_WB: begin
          ctrl.reg_wr   = 1'b1;
          ctrl.regdst   = is_r;
          ctrl.memtoreg = is_lw;
        end
        default: begin
          ctrl = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_FETCH;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
    end
  end

  assign bus.pc_wr     = ctrl.pc_wr;
  assign bus.ir_wr     = ctrl.ir_wr;
  assign bus.reg_wr    = ctrl.reg_wr;
  assign bus.mem_read  = ctrl.mem_read;
  assign bus.mem_write = ctrl.mem_write;
  assign bus.regdst    = ctrl.regdst;
  assign bus.alusrc    = ctrl.alusrc;
  assign bus.memtoreg  = ctrl.memtoreg;
  assign bus.pcsrc     = ctrl.pcsrc;
  assign bus.jump      = ctrl.jump;
  assign bus.aluop     = ctrl.aluop;

  assign state = state_q;
  assign err   = err_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl -- directed bench for multicycle_ctrl.
// Inputs change on the falling edge; outputs are checked 1 ns later, well
// away from the rising edge that advances the FSM.
module tb_multicycle_ctrl;
  import mc_pkg::*;

  // Output vector layout: {pc_wr, ir_wr, reg_wr, mem_read, mem_write,
  //                        regdst, alusrc, memtoreg, pcsrc, jump, aluop}
  localparam logic [11:0] O_NONE     = 12'h000;
  localparam logic [11:0] O_PCWR     = 12'h800;
  localparam logic [11:0] O_IRWR     = 12'h400;
  localparam logic [11:0] O_REGWR    = 12'h200;
  localparam logic [11:0] O_MRD      = 12'h100;
  localparam logic [11:0] O_MWR      = 12'h080;
  localparam logic [11:0] O_REGDST   = 12'h040;
  localparam logic [11:0] O_ALUSRC   = 12'h020;
  localparam logic [11:0] O_MEMTOREG = 12'h010;
  localparam logic [11:0] O_PCSRC    = 12'h008;
  localparam logic [11:0] O_JUMP     = 12'h004;
  localparam logic [11:0] O_FUNCT    = 12'h002;
  localparam logic [11:0] O_SUB      = 12'h001;
  localparam logic [11:0] F_HIT      = O_PCWR | O_IRWR | O_MRD;

`ifdef MULTICYCLE_JUMP_EN
  localparam logic [11:0] J_DEC_EXP = O_PCWR | O_JUMP;
  localparam logic        J_ERR_EXP = 1'b0;
`else
  localparam logic [11:0] J_DEC_EXP = O_NONE;
  localparam logic        J_ERR_EXP = 1'b1;
`endif

  // clock / reset
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [2:0] state;
  logic       err;
  logic [11:0] outs;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  multicycle_ctrl_if bus ();

  multicycle_ctrl #(
    .MEM_WAIT_MAX (15),
    .CNT_W        (4)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .bus   (bus),
    .state (state),
    .err   (err)
  );

  assign outs = {bus.pc_wr, bus.ir_wr, bus.reg_wr, bus.mem_read, bus.mem_write,
                 bus.regdst, bus.alusrc, bus.memtoreg, bus.pcsrc, bus.jump, bus.aluop};

  // driver / checker tasks
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [2:0] exp_st,
                         input logic exp_err, input logic [11:0] exp_o);
    chk({tag, ".state"}, 16'(state), 16'(exp_st));
    chk({tag, ".err"},   16'(err),   16'(exp_err));
    chk({tag, ".outs"},  16'(outs),  16'(exp_o));
  endtask

  task automatic cyc(input string tag, input logic [5:0] op, input logic z,
                     input logic rdy, input logic [2:0] exp_st,
                     input logic exp_err, input logic [11:0] exp_o);
    @(negedge clk);
    bus.opcode    = op;
    bus.zero      = z;
    bus.mem_ready = rdy;
    #1;
    chk_all(tag, exp_st, exp_err, exp_o);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.opcode    = OP_RTYPE;
    bus.zero      = 1'b0;
    bus.mem_ready = 1'b0;

    // reset state, then release
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk_all("reset", ST_FETCH, 1'b0, O_NONE);
    rst = 1'b1;

    // add (R-type): 0,1,2,4
    cyc("add_f",  OP_RTYPE, 1'b0, 1'b1, ST_FETCH,  1'b0, F_HIT);
    cyc("add_d",  OP_RTYPE, 1'b0, 1'b1, ST_DECODE, 1'b0, O_NONE);
    cyc("add_e",  OP_RTYPE, 1'b0, 1'b1, ST_EXEC,   1'b0, O_FUNCT);
    cyc("add_wb", OP_RTYPE, 1'b0, 1'b1, ST_WB,     1'b0, O_REGWR | O_REGDST);
    // lw: 0,1,2,3,4
    cyc("lw_f",   OP_LW, 1'b0, 1'b1, ST_FETCH,  1'b0, F_HIT);
    cyc("lw_d",   OP_LW, 1'b0, 1'b1, ST_DECODE, 1'b0, O_NONE);
    cyc("lw_e",   OP_LW, 1'b0, 1'b1, ST_EXEC,   1'b0, O_ALUSRC);
    cyc("lw_m",   OP_LW, 1'b0, 1'b1, ST_MEM,    1'b0, O_MRD);
    cyc("lw_wb",  OP_LW, 1'b0, 1'b1, ST_WB,     1'b0, O_REGWR | O_MEMTOREG);
    // sw: 0,1,2,3
    cyc("sw_f",   OP_SW, 1'b0, 1'b1, ST_FETCH,  1'b0, F_HIT);
    cyc("sw_d",   OP_SW, 1'b0, 1'b1, ST_DECODE, 1'b0, O_NONE);
    cyc("sw_e",   OP_SW, 1'b0, 1'b1, ST_EXEC,   1'b0, O_ALUSRC);
    cyc("sw_m",   OP_SW, 1'b0, 1'b1, ST_MEM,    1'b0, O_MWR);
    // beq taken: 0,1,2
    cyc("beq1_f", OP_BEQ, 1'b1, 1'b1, ST_FETCH,  1'b0, F_HIT);
    cyc("beq1_d", OP_BEQ, 1'b1, 1'b1, ST_DECODE, 1'b0, O_NONE);
    cyc("beq1_e", OP_BEQ, 1'b1, 1'b1, ST_EXEC,   1'b0, O_SUB | O_PCSRC | O_PCWR);
    // beq not taken
    cyc("beq0_f", OP_BEQ, 1'b0, 1'b1, ST_FETCH,  1'b0, F_HIT);
    cyc("beq0_d", OP_BEQ, 1'b0, 1'b1, ST_DECODE, 1'b0, O_NONE);
    cyc("beq0_e", OP_BEQ, 1'b0, 1'b1, ST_EXEC,   1'b0, O_SUB);

    // lw with 3 wait cycles in MEM
    cyc("lww_f",  OP_LW, 1'b0, 1'b1, ST_FETCH,  1'b0, F_HIT);
    cyc("lww_d",  OP_LW, 1'b0, 1'b1, ST_DECODE, 1'b0, O_NONE);
    cyc("lww_e",  OP_LW, 1'b0, 1'b1, ST_EXEC,   1'b0, O_ALUSRC);
    for (int i = 0; i < 3; i++)
      cyc("lww_mwait", OP_LW, 1'b0, 1'b0, ST_MEM, 1'b0, O_MRD);
    cyc("lww_mdone", OP_LW, 1'b0, 1'b1, ST_MEM, 1'b0, O_MRD);
    cyc("lww_wb",    OP_LW, 1'b0, 1'b1, ST_WB,  1'b0, O_REGWR | O_MEMTOREG);

    // fetch timeout: 15 low cycles, last one drops the request
    for (int i = 0; i < 14; i++)
      cyc("to_wait", OP_RTYPE, 1'b0, 1'b0, ST_FETCH, 1'b0, O_MRD);
    cyc("to_hit", OP_RTYPE, 1'b0, 1'b0, ST_FETCH, 1'b0, O_NONE);
    cyc("to_err", OP_RTYPE, 1'b0, 1'b0, ST_FETCH, 1'b1, O_MRD);
    // ready on the 15th cycle is a normal completion
    for (int i = 0; i < 13; i++)
      cyc("edge_wait", OP_RTYPE, 1'b0, 1'b0, ST_FETCH, 1'b0, O_MRD);
    cyc("edge_ok", OP_RTYPE, 1'b0, 1'b1, ST_FETCH, 1'b0, F_HIT);

    // illegal opcode in DECODE
    cyc("ill_d", 6'h3f, 1'b0, 1'b0, ST_DECODE, 1'b0, O_NONE);
    cyc("ill_f", 6'h3f, 1'b0, 1'b1, ST_FETCH,  1'b1, F_HIT);

    // j
    cyc("j_d", OP_J, 1'b0, 1'b0, ST_DECODE, 1'b0,      J_DEC_EXP);
    cyc("j_f", OP_J, 1'b0, 1'b0, ST_FETCH,  J_ERR_EXP, O_MRD);

    // reset asserted during MEM of lw
    cyc("rlw_f", OP_LW, 1'b0, 1'b1, ST_FETCH,  1'b0, F_HIT);
    cyc("rlw_d", OP_LW, 1'b0, 1'b1, ST_DECODE, 1'b0, O_NONE);
    cyc("rlw_e", OP_LW, 1'b0, 1'b1, ST_EXEC,   1'b0, O_ALUSRC);
    cyc("rlw_m", OP_LW, 1'b0, 1'b0, ST_MEM,    1'b0, O_MRD);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk_all("rst_mid", ST_FETCH, 1'b0, O_NONE);
    @(negedge clk);
    #1;
    chk_all("rst_hold", ST_FETCH, 1'b0, O_NONE);
    rst = 1'b1;
    cyc("rel_f", OP_LW, 1'b0, 1'b0, ST_FETCH, 1'b0, O_MRD);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
